// File: rtl/task2_13_gate_pkg.sv
// Shared types and standard truth tables for the programmable two-input gate.
// Table bit index is {x,y}.
package task2_13_gate_pkg;

   typedef logic [3:0] tt_t;

   localparam tt_t TT_XOR  = 4'b0110;
   localparam tt_t TT_AND  = 4'b1000;
   localparam tt_t TT_OR   = 4'b1110;
   localparam tt_t TT_NAND = 4'b0111;
   localparam tt_t TT_NOR  = 4'b0001;
   localparam tt_t TT_XNOR = 4'b1001;

endpackage

// File: rtl/task2_13_edge_cnt.sv
// Saturating counter of z_q 0->1 transitions; cleared only by reset.
module task2_13_edge_cnt
   import task2_13_gate_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             z_q,
   input  logic             z_q_next,
   output logic [CNT_W-1:0] rise_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // z_q_next is the value z_q takes at this edge, so the count moves on the
   // same edge as the register rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_cnt <= '0;
      end else if (!z_q && z_q_next && (rise_cnt != CNT_MAX)) begin
         rise_cnt <= rise_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/task2_13_gate.sv
// Programmable two-input Boolean cell: 4-entry truth table indexed by {x,y},
// combinational z, registered z_q, and a saturating z_q rising-edge counter.
module task2_13_gate
   import task2_13_gate_pkg::*;
#(
   parameter tt_t DEFAULT_TT = TT_XOR,
   parameter int  CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x,
   input  logic             y,
   input  logic             tt_we,
   input  logic [3:0]       tt_wdata,
   output logic             z,
   output logic             z_q,
   output logic [3:0]       tt,
   output logic [CNT_W-1:0] rise_cnt
);

   tt_t tt_reg;

   assign z  = tt_reg[{x, y}];
   assign tt = tt_reg;

   // z_q samples z from the table as it stood before any write at this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tt_reg <= DEFAULT_TT;
         z_q    <= 1'b0;
      end else begin
         z_q <= z;
         if (tt_we) begin
            tt_reg <= tt_wdata;
         end
      end
   end

   task2_13_edge_cnt #(
      .CNT_W(CNT_W)
   ) u_edge_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .z_q     (z_q),
      .z_q_next(z),
      .rise_cnt(rise_cnt)
   );

endmodule

// File: tb/tb_task2_13_gate.sv
// Bench for task2_13_gate: directed vector table, corner sequences and
// randomized stimulus against a truth-table reference model.
module tb_task2_13_gate;
   import task2_13_gate_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       x = 1'b0, y = 1'b0, tt_we = 1'b0;
   logic [3:0] tt_wdata = 4'b0000;

   logic       z, z_q, z_s, zq_s;
   logic [3:0] tt, tt_s;
   logic [7:0] rise_cnt;
   logic [1:0] cnt_s;

   int n_checks = 0;
   int n_fail = 0;

   // reference model state
   logic [3:0] m_tt = TT_XOR;
   logic       m_zq = 1'b0;
   int         m_cnt = 0;
   int         m_cnt2 = 0;

   always #5 clk = ~clk;

   task2_13_gate dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .tt_we(tt_we), .tt_wdata(tt_wdata),
      .z(z), .z_q(z_q), .tt(tt), .rise_cnt(rise_cnt)
   );

   task2_13_gate #(.CNT_W(2)) dut_s (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .tt_we(tt_we), .tt_wdata(tt_wdata),
      .z(z_s), .z_q(zq_s), .tt(tt_s), .rise_cnt(cnt_s)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_tt   = TT_XOR;
      m_zq   = 1'b0;
      m_cnt  = 0;
      m_cnt2 = 0;
   endtask

   // One rising edge: advance the model from the bench's own inputs, then compare.
   task automatic edge_update();
      logic zn;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         zn = m_tt[{x, y}];
         if (!m_zq && zn) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
         end
         if (tt_we) m_tt = tt_wdata;
         m_zq = zn;
      end
      #1;
      check("model_zq", z_q, m_zq);
      check("model_tt", tt, m_tt);
      check("model_cnt", rise_cnt, m_cnt);
      check("model_cnt_w2", cnt_s, m_cnt2);
      check("model_zq_w2", zq_s, m_zq);
   endtask

   task automatic drive(input logic xi, input logic yi, input logic wei, input logic [3:0] wd);
      x = xi; y = yi; tt_we = wei; tt_wdata = wd;
      #2;
      check("model_z", z, m_tt[{xi, yi}]);
   endtask

   task automatic step(input logic xi, input logic yi, input logic wei, input logic [3:0] wd);
      drive(xi, yi, wei, wd);
      edge_update();
   endtask

   typedef struct {
      logic       x, y, we;
      logic [3:0] wd;
      logic       ez, ezq;
      logic [3:0] ett;
      logic [7:0] ecnt;
   } vec_t;

   vec_t vecs[9];

   initial begin
      // XOR sweep, AND written while z reads 1 under XOR, then AND sweep
      vecs[0] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'b0110, 8'd0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0110, 8'd1};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0110, 8'd1};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'b0110, 8'd1};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b1000, 8'd2};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'b1000, 8'd2};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'b1000, 8'd2};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'b1000, 8'd2};
      vecs[8] = '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b1000, 8'd3};

      // reset with a write request pending: must be ignored
      rst_n = 1'b0; tt_we = 1'b1; tt_wdata = 4'b0001;
      model_reset();
      repeat (3) edge_update();
      check("rst_tt", tt, 4'b0110);
      check("rst_zq", z_q, 1'b0);
      check("rst_cnt", rise_cnt, 8'd0);
      check("rst_z_00", z, 1'b0);
      tt_we = 1'b0; tt_wdata = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;
      edge_update();
      check("wr_in_rst_tt", tt, 4'b0110);

      foreach (vecs[i]) begin
         drive(vecs[i].x, vecs[i].y, vecs[i].we, vecs[i].wd);
         check($sformatf("vec%0d_z", i), z, vecs[i].ez);
         edge_update();
         check($sformatf("vec%0d_zq", i), z_q, vecs[i].ezq);
         check($sformatf("vec%0d_tt", i), tt, vecs[i].ett);
         check($sformatf("vec%0d_cnt", i), rise_cnt, vecs[i].ecnt);
      end

      // edge count: fresh reset, XOR, y toggled five times with x=0
      rst_n = 1'b0; x = 1'b0; y = 1'b0; tt_we = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      edge_update();
      repeat (5) begin
         step(1'b0, 1'b1, 1'b0, 4'h0);
         step(1'b0, 1'b0, 1'b0, 4'h0);
      end
      check("toggle5_cnt", rise_cnt, 8'd5);
      check("toggle5_cnt_w2_sat", cnt_s, 2'd3);

      // async reset mid-operation under OR with a pending write
      step(1'b1, 1'b0, 1'b1, TT_OR);
      step(1'b1, 1'b0, 1'b0, 4'h0);
      check("or_z_10", z, 1'b1);
      check("or_tt", tt, TT_OR);
      #2;
      tt_we = 1'b1; tt_wdata = 4'b0001;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_tt", tt, 4'b0110);
      check("async_zq", z_q, 1'b0);
      check("async_cnt", rise_cnt, 8'd0);
      check("async_z_10", z, 1'b1);
      edge_update();
      tt_we = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      edge_update();
      check("after_async_tt", tt, 4'b0110);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom));
      end

      // drive the 8-bit counter into saturation under XOR
      step(1'b0, 1'b0, 1'b1, TT_XOR);
      for (int i = 0; i < 540; i++) begin
         step(1'b0, 1'(i % 2 == 0), 1'b0, 4'h0);
      end
      check("sat_cnt", rise_cnt, 8'd255);
      check("sat_cnt_w2", cnt_s, 2'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
